// File: rtl/loader_sdram_bridge_pkg.sv
// Shared constants and payload type for the game_loader -> SDRAM write bridge.
package loader_bridge_pkg;

  localparam int unsigned LOADER_ADDR_W  = 22;
  localparam logic [1:0]  NES_SLOT_PHASE = 2'd3;

  typedef struct packed {
    logic [LOADER_ADDR_W-1:0] addr;
    logic [7:0]               data;
  } loader_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy counter; caller guarantees no push
// when full without a pop, and no pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/loader_sdram_bridge.sv
// Buffers loader byte writes and replays them into the SDRAM write port,
// one write per ce_phase slot, gating the done flag until the buffer drains.
module loader_sdram_bridge
  import loader_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = LOADER_ADDR_W,
  parameter int unsigned DEPTH      = 8,
  parameter logic [1:0]  SLOT_PHASE = NES_SLOT_PHASE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  input  logic [1:0]                ce_phase,
  input  logic                      loader_done,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_din,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      overflow,
  output logic                      done
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned WW = ADDR_W + 8;

  logic          slot;
  logic          pop_now;
  logic          push;
  logic [WW-1:0] head;

  assign slot     = (ce_phase == SLOT_PHASE);
  assign pop_now  = slot && (fill_level != '0);
  // A pop on this edge frees a slot, so a full FIFO can still take a byte.
  assign in_ready = (fill_level != CW'(DEPTH)) || pop_now;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop_now),
    .wdata   ({in_addr, in_data}),
    .rdata   (head),
    .count   (fill_level)
  );

  // Write port only changes on slot edges, so each write spans a full window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      if (slot) begin
        mem_we <= pop_now;
        if (pop_now) begin
          mem_addr <= head[WW-1:8];
          mem_din  <= head[7:0];
        end
      end
      if (!loader_done) done <= 1'b0;
      else              done <= (fill_level == '0) && !mem_we;
    end
  end

endmodule

// File: tb/tb_loader_sdram_bridge.sv
// Scoreboard bench for loader_sdram_bridge: queue-level reference model plus a
// negedge monitor that pops expected writes as the DUT issues them.
module tb_loader_sdram_bridge;
  import loader_bridge_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = LOADER_ADDR_W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_data;
  logic          in_ready;
  logic [1:0]    ce_phase = 2'd0;
  logic          loader_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [3:0]    fill_level;
  logic          overflow;
  logic          done;

  int errors = 0;
  int checks = 0;
  int writes_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ce_phase <= ce_phase + 2'd1;

  loader_sdram_bridge #(
    .ADDR_W     (AW),
    .DEPTH      (DEPTH),
    .SLOT_PHASE (NES_SLOT_PHASE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ce_phase    (ce_phase),
    .loader_done (loader_done),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .fill_level  (fill_level),
    .overflow    (overflow),
    .done        (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending bytes drained one per slot edge.
  loader_wr_t    pend[$];
  loader_wr_t    exp_q[$];
  logic          m_we   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_din  = '0;
  logic          m_ovf  = 1'b0;
  logic          m_done = 1'b0;
  bit            started = 1'b0;

  always @(posedge clk) begin : model
    int         old_size;
    logic       old_we;
    logic       is_slot;
    logic       can_pop;
    logic       ready;
    loader_wr_t w;
    old_size = pend.size();
    old_we   = m_we;
    is_slot  = (ce_phase == NES_SLOT_PHASE);
    can_pop  = is_slot && old_size != 0;
    ready    = (old_size != DEPTH) || can_pop;
    started  = 1'b1;
    if (!reset_n) begin
      pend.delete();
      exp_q.delete();
      m_we = 1'b0; m_addr = '0; m_din = '0; m_ovf = 1'b0; m_done = 1'b0;
    end else begin
      if (is_slot) begin
        if (can_pop) begin
          w = pend.pop_front();
          m_we = 1'b1; m_addr = w.addr; m_din = w.data;
        end else begin
          m_we = 1'b0;
        end
      end
      if (in_valid) begin
        if (ready) begin
          w.addr = in_addr;
          w.data = in_data;
          pend.push_back(w);
          exp_q.push_back(w);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_done = loader_done && old_size == 0 && !old_we;
    end
  end

  // Monitor: per-cycle state compare plus scoreboard pop on each new write.
  always @(negedge clk) begin : monitor
    loader_wr_t w;
    if (started) begin
      chk("fill_level", 32'(fill_level), 32'(pend.size()));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_din", 32'(mem_din), 32'(m_din));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("done", 32'(done), 32'(m_done));
      chk("in_ready", 32'(in_ready),
          32'((pend.size() != DEPTH) || (ce_phase == NES_SLOT_PHASE && pend.size() != 0)));
      if (mem_we && ce_phase == NES_SLOT_PHASE + 2'd1) begin
        writes_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none at %0t",
                   mem_addr, mem_din, $time);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.addr));
          chk("wr_data", 32'(mem_din), 32'(w.data));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
    in_valid = 1'b1; in_addr = a; in_data = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 4 && ce_phase != p; i++) step();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w0;
    reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; loader_done = 1'b0;
    idle(3);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    step();

    // Single byte: pushed on a phase-0 edge, issued on the following phase-3 edge.
    wait_phase(2'd0);
    push(22'h000010, 8'hA5);
    idle(2);
    chk("single_we_early", 32'(mem_we), 32'd0);
    step();
    chk("single_we_rise", 32'(mem_we), 32'd1);
    chk("single_addr", 32'(mem_addr), 32'h10);
    chk("single_data", 32'(mem_din), 32'hA5);
    idle(3);
    chk("single_we_hold", 32'(mem_we), 32'd1);
    step();
    chk("single_we_fall", 32'(mem_we), 32'd0);
    chk("single_fill", 32'(fill_level), 32'd0);
    idle(4);

    // Burst of DEPTH back-to-back pushes: no drop.
    w0 = writes_seen;
    wait_phase(2'd0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_addr = 22'h000100 + 22'(i); in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    idle(40);
    chk("burst_ovf", 32'(overflow), 32'd0);
    chk("burst_writes", 32'(writes_seen - w0), 32'd8);

    // Overflow: 12 pushes from phase 0, only the 11th meets a full FIFO without a pop.
    w0 = writes_seen;
    wait_phase(2'd0);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_addr = 22'h000200 + 22'(i); in_data = 8'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    idle(60);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_writes", 32'(writes_seen - w0), 32'd11);
    idle(8);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Slot coincidence: push into empty FIFO on a phase-3 edge waits a full slot.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    wait_phase(2'd3);
    push(22'h000300, 8'h5C);
    chk("coin_no_pop", 32'(mem_we), 32'd0);
    chk("coin_fill", 32'(fill_level), 32'd1);
    idle(3);
    chk("coin_we_wait", 32'(mem_we), 32'd0);
    step();
    chk("coin_we_rise", 32'(mem_we), 32'd1);
    chk("coin_addr", 32'(mem_addr), 32'h300);
    idle(8);

    // Push plus pop at full keeps fill_level at DEPTH.
    wait_phase(2'd0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_addr = 22'h000400 + 22'(i); in_data = 8'(8'h80 + i);
      step();
    end
    in_valid = 1'b0;
    chk("full_fill", 32'(fill_level), 32'd8);
    chk("full_not_ready", 32'(in_ready), 32'd0);
    step();
    chk("full_slot_ready", 32'(in_ready), 32'd1);
    push(22'h00040A, 8'h8A);
    chk("full_pushpop_fill", 32'(fill_level), 32'd8);
    chk("full_no_drop", 32'(overflow), 32'd0);
    idle(44);

    // Done gating with three queued bytes.
    wait_phase(2'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 22'h000500 + 22'(i); in_data = 8'(8'hC0 + i);
      step();
    end
    in_valid = 1'b0;
    loader_done = 1'b1;
    idle(13);
    chk("done_gated", 32'(done), 32'd0);
    chk("done_we_end", 32'(mem_we), 32'd0);
    step();
    chk("done_rise", 32'(done), 32'd1);
    loader_done = 1'b0;
    step();
    chk("done_drop", 32'(done), 32'd0);
    loader_done = 1'b1;
    idle(2);
    chk("done_again", 32'(done), 32'd1);
    push(22'h000600, 8'hEE);
    idle(12);
    loader_done = 1'b0;
    idle(4);

    // Reset mid-burst: writes in flight and queued bytes are discarded.
    wait_phase(2'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_addr = 22'h000700 + 22'(i); in_data = 8'(8'h10 + i);
      step();
    end
    in_valid = 1'b0;
    chk("midrst_fill_pre", 32'(fill_level), 32'd5);
    chk("midrst_we_pre", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_fill", 32'(fill_level), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    w0 = writes_seen;
    idle(30);
    chk("midrst_no_writes", 32'(writes_seen - w0), 32'd0);

    // Randomized traffic with bursty and sparse phases, occasional resets.
    for (int blk = 0; blk < 12; blk++) begin
      int rate;
      rate = ($urandom_range(0, 1) == 0) ? 20 : 85;
      for (int c = 0; c < 50; c++) begin
        in_valid = ($urandom_range(0, 99) < rate);
        in_addr  = AW'($urandom());
        in_data  = 8'($urandom());
        if ($urandom_range(0, 99) < 3) loader_done = ~loader_done;
        reset_n  = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    in_valid = 1'b0;
    reset_n  = 1'b1;
    loader_done = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || mem_we); i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(3);
    chk("final_done", 32'(done), 32'd1);
    chk("final_fill", 32'(fill_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
